axonerve_wordcount_rtl_example_axi_read_issuer: RTL and testbench
=================================================================

Name: axonerve_wordcount_rtl_example_axi_read_issuer

Overview:
AXI4 read-address issuer for the wordcount kernel's read master. Takes a start/address/byte-count command from the control block and splits the transfer into fixed-length AR bursts. Tracks outstanding bursts, incrementing on each AR handshake and decrementing on each R last beat, and throttles issue at a configurable limit. Sits directly upstream of the read data path; pulses done once every issued burst has returned its last beat.

Parameters:
C_ADDR_WIDTH, 64, AXI address width
C_DATA_WIDTH, 512, AXI data width in bits; bytes per beat BPB = C_DATA_WIDTH/8
C_XFER_SIZE_WIDTH, 32, width of byte-count input
C_BURST_LEN, 64, beats per full burst (power of 2, 1..256)
C_MAX_OUTSTANDING, 16, maximum in-flight bursts (>=1)

Ports:
clk  in  1  kernel clock
rst  in  1  reset, asynchronous, active-high
ctrl_start  in  1  single-cycle start pulse
ctrl_addr_offset  in  C_ADDR_WIDTH  byte start address
ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  transfer length in bytes
ctrl_done  out  1  single-cycle completion pulse
busy  out  1  high from the start-accept cycle until the done cycle, inclusive
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  C_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats minus one
r_last_done  in  1  one R last-beat handshake this cycle (rvalid&rready&rlast)
outstanding  out  clog2(C_MAX_OUTSTANDING+1)  in-flight burst count

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst). While rst is high, all outputs and state go to 0 immediately and the FSM is IDLE. A reset mid-transfer abandons the transfer with no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ctrl_start latches the start address with its low log2(BPB) bits forced to 0.
  - total_beats = ceil(size/BPB).
  - bursts = ceil(total_beats/C_BURST_LEN).
  - last_len = total_beats - (bursts-1)*C_BURST_LEN.
  - If size==0, go to DONE. Otherwise go to ISSUE.
  - busy rises the cycle after start.
- ctrl_start outside IDLE is ignored.
- ISSUE:
  - m_axi_arvalid = (bursts_remaining!=0) && (outstanding != C_MAX_OUTSTANDING), registered.
  - Once asserted, arvalid, araddr and arlen hold stable until the arready handshake. They never drop or change without a handshake.
  - arlen = C_BURST_LEN-1, except the final burst uses last_len-1.
  - After each handshake, araddr += C_BURST_LEN*BPB and bursts_remaining -= 1.
  - Back-to-back handshakes on consecutive cycles are supported (throughput 1 AR/cycle).
  - When bursts_remaining reaches 0, go to DRAIN.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: ctrl_done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- Outstanding counter:
  - +1 on AR handshake only; -1 on r_last_done only; simultaneous events leave it unchanged.
  - r_last_done with outstanding==0 is ignored; the count saturates at 0.
  - The count never exceeds C_MAX_OUTSTANDING. The issue rule guarantees this.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH.
- 4 KB boundary compliance is the caller's responsibility: the start address must be aligned to C_BURST_LEN*BPB when C_BURST_LEN*BPB<=4096.
- Latency: first arvalid appears 2 cycles after the ctrl_start cycle. ctrl_done appears 1 cycle after the cycle in which outstanding returns to 0 with no bursts remaining.

Test Plan:
1. Defaults, addr=0x1000, size=8192 -> two ARs: (0x1000, arlen 63), (0x2000, arlen 63). Return both r_last_done -> ctrl_done one pulse one cycle later; outstanding back to 0.
2. size=100, addr=0x3F -> one AR with araddr=0x0 and arlen=1 (2 beats); done after a single r_last_done.
3. size=0 -> no arvalid ever; ctrl_done pulse; busy drops after one cycle.
4. C_MAX_OUTSTANDING=2, size=5*4096, arready=1, no r_last_done -> exactly 2 AR handshakes, then arvalid low and outstanding=2. One r_last_done -> third AR issues. Same cycle as a handshake plus r_last_done -> count unchanged.
5. Hold arready=0 for 10 cycles with arvalid high -> arvalid, araddr and arlen stable throughout. ctrl_start pulsed while busy -> ignored.
6. Assert rst mid-ISSUE with outstanding=3 -> arvalid=0, outstanding=0, busy=0 immediately, no done. A new start after reset completes normally.

Source files
------------

// File: rtl/axonerve_wordcount_rtl_example_axi_read_issuer_if.sv
// rtl/axonerve_wordcount_rtl_example_axi_read_issuer_if.sv - AR channel and R-last bundle for the read issuer
interface axonerve_wordcount_rtl_example_axi_read_issuer_if #(
    parameter int C_ADDR_WIDTH = 64
);
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic                    r_last_done;

    modport master (
        output arvalid,
        output araddr,
        output arlen,
        input  arready,
        input  r_last_done
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  arlen,
        output arready,
        output r_last_done
    );
endinterface

// File: rtl/axonerve_wordcount_rtl_example_axi_read_issuer.sv
// rtl/axonerve_wordcount_rtl_example_axi_read_issuer.sv - splits a byte-count read into fixed AR bursts with outstanding throttle
module axonerve_wordcount_rtl_example_axi_read_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16,
    localparam int OUT_W            = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    output logic                         busy,
    axonerve_wordcount_rtl_example_axi_read_issuer_if.master m_axi,
    output logic [OUT_W-1:0]             outstanding
);
    localparam int BPB     = C_DATA_WIDTH / 8;
    localparam int BPB_LOG = $clog2(BPB);
    localparam int BL_LOG  = $clog2(C_BURST_LEN);
    localparam int TB_W    = C_XFER_SIZE_WIDTH + 1;

    localparam logic [OUT_W-1:0]        MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BPB);
    localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK  = ~C_ADDR_WIDTH'(BPB - 1);
    localparam logic [7:0]              FULL_ARLEN  = 8'(C_BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [TB_W-1:0] bursts_remaining;
    logic [8:0]      last_len;

    logic [TB_W-1:0] total_beats;
    logic [TB_W-1:0] n_bursts;
    logic [TB_W-1:0] burst_frac;
    logic [8:0]      last_len_c;

    logic            hs;
    logic            rl;
    logic [OUT_W-1:0] out_next;
    logic [TB_W-1:0] rem_after;

    // Command decode: beats and bursts by shift since BPB and burst length are powers of two
    always_comb begin
        total_beats = TB_W'(ctrl_xfer_size_in_bytes >> BPB_LOG);
        if ((ctrl_xfer_size_in_bytes & C_XFER_SIZE_WIDTH'(BPB - 1)) != '0) begin
            total_beats = total_beats + TB_W'(1);
        end
        n_bursts   = total_beats >> BL_LOG;
        burst_frac = total_beats & TB_W'(C_BURST_LEN - 1);
        if (burst_frac != '0) begin
            n_bursts = n_bursts + TB_W'(1);
        end
        last_len_c = (burst_frac == '0) ? 9'(C_BURST_LEN) : 9'(burst_frac);
    end

    // Handshake events and next in-flight count; a stray R-last at zero is dropped
    always_comb begin
        hs        = m_axi.arvalid && m_axi.arready;
        rl        = m_axi.r_last_done && (outstanding != '0);
        out_next  = outstanding;
        if (hs && !rl) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!hs && rl) begin
            out_next = outstanding - OUT_W'(1);
        end
        rem_after = hs ? (bursts_remaining - TB_W'(1)) : bursts_remaining;
    end

    // Control FSM with registered AR outputs, busy/done flags and outstanding counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bursts_remaining <= '0;
            last_len         <= '0;
            outstanding      <= '0;
            ctrl_done        <= 1'b0;
            busy             <= 1'b0;
            m_axi.arvalid    <= 1'b0;
            m_axi.araddr     <= '0;
            m_axi.arlen      <= '0;
        end else begin
            outstanding <= out_next;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        busy             <= 1'b1;
                        m_axi.araddr     <= ctrl_addr_offset & ALIGN_MASK;
                        bursts_remaining <= n_bursts;
                        last_len         <= last_len_c;
                        if (ctrl_xfer_size_in_bytes == '0) begin
                            ctrl_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bursts_remaining <= rem_after;
                    if (hs) begin
                        m_axi.araddr <= m_axi.araddr + BURST_BYTES;
                    end
                    // A presented request is frozen until it is accepted
                    if (!m_axi.arvalid || hs) begin
                        m_axi.arvalid <= (rem_after != '0) && (out_next != MAX_OUT);
                        m_axi.arlen   <= (rem_after == TB_W'(1)) ? 8'(last_len - 9'd1) : FULL_ARLEN;
                    end
                    if (rem_after == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        ctrl_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    ctrl_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axonerve_wordcount_rtl_example_axi_read_issuer.sv
// tb/tb_axonerve_wordcount_rtl_example_axi_read_issuer.sv - self-checking bench for the AXI read issuer
module tb_axonerve_wordcount_rtl_example_axi_read_issuer;
    localparam int AW   = 64;
    localparam int XW   = 32;
    localparam int BPB  = 64;
    localparam int BL   = 64;
    localparam int MAXA = 16;
    localparam int MAXB = 2;
    localparam int OWA  = $clog2(MAXA + 1);
    localparam int OWB  = $clog2(MAXB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0;
    logic [AW-1:0] addr_a  = '0;
    logic [XW-1:0] size_a  = '0;
    logic          done_a, busy_a;
    logic [OWA-1:0] out_a;

    logic          start_b = 1'b0;
    logic [AW-1:0] addr_b  = '0;
    logic [XW-1:0] size_b  = '0;
    logic          done_b, busy_b;
    logic [OWB-1:0] out_b;

    axonerve_wordcount_rtl_example_axi_read_issuer_if #(.C_ADDR_WIDTH(AW)) ifa();
    axonerve_wordcount_rtl_example_axi_read_issuer_if #(.C_ADDR_WIDTH(AW)) ifb();

    axonerve_wordcount_rtl_example_axi_read_issuer #(.C_MAX_OUTSTANDING(MAXA)) dut_a (
        .clk(clk), .rst(rst), .ctrl_start(start_a), .ctrl_addr_offset(addr_a),
        .ctrl_xfer_size_in_bytes(size_a), .ctrl_done(done_a), .busy(busy_a),
        .m_axi(ifa), .outstanding(out_a)
    );

    axonerve_wordcount_rtl_example_axi_read_issuer #(.C_MAX_OUTSTANDING(MAXB)) dut_b (
        .clk(clk), .rst(rst), .ctrl_start(start_b), .ctrl_addr_offset(addr_b),
        .ctrl_xfer_size_in_bytes(size_b), .ctrl_done(done_b), .busy(busy_b),
        .m_axi(ifb), .outstanding(out_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: list of expected bursts, in-flight count, done/busy expectations
    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    ar_t q[$];
    int  m_cnt = 0;
    bit  m_active = 0, m_busy = 0, m_done = 0;
    bit  prev_stall = 0;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;
    bit  mon_hs, mon_arm, mon_started;
    ar_t mon_e;

    int          tr_hs = 0, tr_done = 0;
    logic [63:0] tr_first_addr;
    logic [7:0]  tr_first_len, tr_last_len;

    task automatic build(input logic [63:0] a0, input logic [31:0] s);
        logic [63:0] a;
        longint      beats;
        int          n;
        ar_t         e;
        a     = a0 & ~64'(BPB - 1);
        beats = (longint'(s) + BPB - 1) / BPB;
        q.delete();
        while (beats > 0) begin
            n      = (beats > BL) ? BL : int'(beats);
            e.addr = a;
            e.len  = 8'(n - 1);
            q.push_back(e);
            a      = a + 64'(BL * BPB);
            beats  = beats - n;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = 0; m_active = 0; m_busy = 0; m_done = 0; prev_stall = 0;
            check("rst_arvalid", 64'(ifa.arvalid), 0);
            check("rst_outstanding", 64'(out_a), 0);
            check("rst_busy", 64'(busy_a), 0);
            check("rst_done", 64'(done_a), 0);
        end else begin
            check("done", 64'(done_a), 64'(m_done));
            check("busy", 64'(busy_a), 64'(m_busy));
            check("outstanding", 64'(out_a), 64'(m_cnt));
            check("out_le_max", 64'(out_a <= MAXA), 1);
            if (ifa.arvalid) check("arvalid_with_work", 64'(q.size() != 0), 1);
            if (prev_stall) begin
                check("stall_arvalid", 64'(ifa.arvalid), 1);
                check("stall_araddr", ifa.araddr, prev_addr);
                check("stall_arlen", 64'(ifa.arlen), 64'(prev_len));
            end
            mon_hs      = ifa.arvalid && ifa.arready;
            mon_started = 0;
            if (!m_active && start_a) begin
                build(addr_a, size_a);
                m_active = 1; mon_started = 1;
                tr_hs = 0; tr_done = 0;
            end
            mon_arm = m_active && (q.size() == 0) && (m_cnt == 0) && !m_done;
            if (m_done) begin
                m_active = 0; m_busy = 0;
            end else if (mon_started) begin
                m_busy = 1;
            end
            if (done_a) tr_done++;
            if (mon_hs) begin
                if (tr_hs == 0) begin
                    tr_first_addr = ifa.araddr;
                    tr_first_len  = ifa.arlen;
                end
                tr_last_len = ifa.arlen;
                tr_hs++;
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("ar_addr", ifa.araddr, mon_e.addr);
                    check("ar_len", 64'(ifa.arlen), 64'(mon_e.len));
                end
            end
            if (ifa.r_last_done && m_cnt > 0) m_cnt--;
            if (mon_hs) m_cnt++;
            m_done     = mon_arm;
            prev_stall = ifa.arvalid && !ifa.arready;
            prev_addr  = ifa.araddr;
            prev_len   = ifa.arlen;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_xfer(input logic [63:0] a, input logic [31:0] s);
        start_a = 1'b1; addr_a = a; size_a = s;
        tick();
        start_a = 1'b0;
    endtask

    task automatic run_a(input int rdy_pct, input int rl_pct, input bit spur);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done_a) begin ok = 1; break; end
            ifa.arready     = ($urandom_range(0, 99) < rdy_pct);
            ifa.r_last_done = (m_cnt > 0) && ($urandom_range(0, 99) < rl_pct);
            start_a         = spur && busy_a && !done_a && ($urandom_range(0, 15) == 0);
            if (start_a) begin addr_a = {$urandom, $urandom}; size_a = $urandom_range(0, 9000); end
            tick();
        end
        ifa.arready = 0; ifa.r_last_done = 0; start_a = 0;
        check("done_within_budget", 64'(ok), 1);
    endtask

    typedef struct {
        logic [63:0] addr; logic [31:0] size; int bursts;
        logic [63:0] first_addr; logic [7:0] first_len; logic [7:0] last_len;
    } vec_t;
    vec_t tbl[9];

    int          hs_b;
    bit          ok_b;
    logic [63:0] a0;
    logic [7:0]  l0;

    initial begin
        tbl[0] = '{64'h1000, 8192, 2, 64'h1000, 63, 63};
        tbl[1] = '{64'h3F, 100, 1, 64'h0, 1, 1};
        tbl[2] = '{64'h5000, 0, 0, 64'h0, 0, 0};
        tbl[3] = '{64'h2000, 4096, 1, 64'h2000, 63, 63};
        tbl[4] = '{64'h4000, 4097, 2, 64'h4000, 63, 0};
        tbl[5] = '{64'h0, 64, 1, 64'h0, 0, 0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_F000, 12288, 3, 64'hFFFF_FFFF_FFFF_F000, 63, 63};
        tbl[7] = '{64'h40, 1, 1, 64'h40, 0, 0};
        tbl[8] = '{64'h7000, 6400, 2, 64'h7000, 63, 35};

        ifa.arready = 0; ifa.r_last_done = 0;
        ifb.arready = 0; ifb.r_last_done = 0;
        repeat (3) tick();
        check("reset_arvalid", 64'(ifa.arvalid), 0);
        check("reset_outstanding", 64'(out_a), 0);
        check("reset_busy", 64'(busy_a), 0);
        check("reset_done", 64'(done_a), 0);
        rst = 0;
        tick();

        // Stray R-last while idle saturates at zero
        ifa.r_last_done = 1;
        repeat (3) tick();
        ifa.r_last_done = 0;
        check("idle_rl_saturate", 64'(out_a), 0);

        // Table-driven transfers
        for (int v = 0; v < 9; v++) begin
            start_a_xfer(tbl[v].addr, tbl[v].size);
            run_a(100, 50, 0);
            tick(); tick();
            check($sformatf("tbl%0d_bursts", v), 64'(tr_hs), 64'(tbl[v].bursts));
            check($sformatf("tbl%0d_done", v), 64'(tr_done), 1);
            if (tbl[v].bursts > 0) begin
                check($sformatf("tbl%0d_first_addr", v), tr_first_addr, tbl[v].first_addr);
                check($sformatf("tbl%0d_first_len", v), 64'(tr_first_len), 64'(tbl[v].first_len));
                check($sformatf("tbl%0d_last_len", v), 64'(tr_last_len), 64'(tbl[v].last_len));
            end
            check($sformatf("tbl%0d_idle_busy", v), 64'(busy_a), 0);
        end

        // Latency, stall hold for 10 cycles, and ignored start while busy
        ifa.arready = 0;
        start_a_xfer(64'h1000, 8192);
        @(negedge clk); check("lat_c1_arvalid", 64'(ifa.arvalid), 0);
        @(negedge clk); check("lat_c2_arvalid", 64'(ifa.arvalid), 1);
        a0 = ifa.araddr; l0 = ifa.arlen;
        check("lat_araddr", a0, 64'h1000);
        check("lat_arlen", 64'(l0), 63);
        for (int i = 0; i < 10; i++) begin
            tick();
            start_a = (i == 3); addr_a = 64'h9000; size_a = 64;
            @(negedge clk);
            check("hold_arvalid", 64'(ifa.arvalid), 1);
            check("hold_araddr", ifa.araddr, a0);
            check("hold_arlen", 64'(ifa.arlen), 64'(l0));
        end
        tick(); start_a = 0;
        run_a(100, 50, 0);
        tick(); tick();
        check("stall_xfer_bursts", 64'(tr_hs), 2);

        // Throttle at two outstanding, simultaneous issue and return
        ifb.arready = 1; ifb.r_last_done = 0;
        start_b = 1; addr_b = 64'h0; size_b = 5 * 4096;
        tick(); start_b = 0;
        hs_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifb.arvalid && ifb.arready) hs_b++;
            tick();
        end
        check("thr_hs_count", 64'(hs_b), 2);
        check("thr_arvalid_low", 64'(ifb.arvalid), 0);
        check("thr_outstanding", 64'(out_b), 2);
        ifb.r_last_done = 1;
        @(negedge clk); check("thr_wait_arvalid", 64'(ifb.arvalid), 0);
        tick();
        @(negedge clk);
        check("thr_third_ar", 64'(ifb.arvalid), 1);
        check("thr_out_after_rl", 64'(out_b), 1);
        tick(); ifb.r_last_done = 0;
        @(negedge clk); check("thr_simul_unchanged", 64'(out_b), 1);
        tick();
        ok_b = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_b) begin ok_b = 1; break; end
            check("thr_out_le_max", 64'(out_b <= MAXB), 1);
            ifb.r_last_done = (out_b > 0);
            tick();
        end
        ifb.r_last_done = 0; ifb.arready = 0;
        check("thr_done", 64'(ok_b), 1);
        tick();
        check("thr_final_out", 64'(out_b), 0);

        // Reset mid-transfer with three in flight
        ifa.arready = 1; ifa.r_last_done = 0;
        start_a_xfer(64'h10000, 5 * 4096);
        ok_b = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_a == 3) begin ok_b = 1; break; end
            tick();
        end
        check("rst_reach_three", 64'(ok_b), 1);
        rst = 1;
        #1;
        check("midrst_arvalid", 64'(ifa.arvalid), 0);
        check("midrst_outstanding", 64'(out_a), 0);
        check("midrst_busy", 64'(busy_a), 0);
        ifa.arready = 0;
        tick(); tick();
        rst = 0;
        repeat (4) tick();
        check("midrst_no_done", 64'(tr_done), 0);
        start_a_xfer(64'h20000, 8192);
        run_a(100, 50, 0);
        tick(); tick();
        check("post_rst_bursts", 64'(tr_hs), 2);
        check("post_rst_done", 64'(tr_done), 1);

        // Randomized transfers against the model
        for (int t = 0; t < 20; t++) begin
            logic [63:0] ra;
            ra = {$urandom, $urandom};
            if (t % 2 == 0) ra = ra & ~64'hFFF;
            start_a_xfer(ra, $urandom_range(0, 24576));
            run_a(70, 40, 1);
            tick(); tick();
            check("rand_all_issued", 64'(q.size()), 0);
            check("rand_done_once", 64'(tr_done), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
